// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV64 pipeline.
// Issues one data-memory access at a time, formats store lanes and load data,
// and owns the MEM/WB register feeding writeback.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd_addr,
  output logic        stall_out,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] mem_result,
  output logic        reg_write,
  output logic [4:0]  rd_addr,
  output logic        mem_fault,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] timer;

  logic [2:0]  off;
  logic [1:0]  size;
  logic        mem_op;
  logic        is_load;
  logic        is_store;
  logic        illegal;
  logic        misaligned;
  logic        good_op;
  logic        fault_op;
  logic        expire;
  logic [63:0] shifted_rdata;
  logic [63:0] load_value;
  logic [7:0]  strobe;

  assign off      = in_alu_result[2:0];
  assign size     = in_funct3[1:0];
  assign mem_op   = in_valid & (in_mem_read | in_mem_write);
  assign is_load  = in_mem_read;
  assign is_store = in_mem_write & ~in_mem_read;
  assign illegal  = is_load ? (in_funct3 == 3'b111) : in_funct3[2];
  assign fault_op = mem_op & (illegal | misaligned);
  assign good_op  = mem_op & ~(illegal | misaligned);

  // The last cycle of the allowed REQ+WAIT window abandons the access.
  assign expire = (state != IDLE) && (timer == TIMER_LAST);

  // Natural alignment check: the offset must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  // Byte strobes for the store lanes touched by this access.
  always_comb begin
    strobe = 8'h00;
    case (size)
      2'd0:    strobe = 8'h01 << off;
      2'd1:    strobe = 8'h03 << off;
      2'd2:    strobe = 8'h0F << off;
      default: strobe = 8'hFF;
    endcase
  end

  // Extract the addressed bytes from the read word and extend them.
  always_comb begin
    shifted_rdata = dmem_rdata >> {off, 3'b000};
    load_value    = shifted_rdata;
    case (in_funct3)
      3'b000:  load_value = {{56{shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001:  load_value = {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b010:  load_value = {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
      3'b100:  load_value = {56'd0, shifted_rdata[7:0]};
      3'b101:  load_value = {48'd0, shifted_rdata[15:0]};
      3'b110:  load_value = {32'd0, shifted_rdata[31:0]};
      default: load_value = shifted_rdata;
    endcase
  end

  // Request fields are only driven while a request is active, so they stay
  // zero out of reset and are stable for the whole handshake.
  always_comb begin
    dmem_req   = (state == REQ);
    dmem_we    = 1'b0;
    dmem_addr  = 64'd0;
    dmem_wdata = 64'd0;
    dmem_wstrb = 8'h00;
    if (state == REQ) begin
      dmem_we   = is_store;
      dmem_addr = {in_alu_result[63:3], 3'b000};
      if (is_store) begin
        dmem_wdata = in_store_data << {off, 3'b000};
        dmem_wstrb = strobe;
      end
    end
  end

  // Hold upstream until the access completes; expiry cycles release it.
  always_comb begin
    stall_out = 1'b0;
    case (state)
      IDLE:    stall_out = good_op;
      REQ:     stall_out = ~(is_store & dmem_ready) & ~expire;
      WAIT:    stall_out = ~dmem_rvalid & ~expire;
      default: stall_out = 1'b0;
    endcase
  end

  // Access FSM, timeout counter and the MEM/WB register; a bubble is the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      mem_result <= 64'd0;
      reg_write  <= 1'b0;
      rd_addr    <= 5'd0;
      mem_fault  <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      mem_result <= 64'd0;
      reg_write  <= 1'b0;
      rd_addr    <= 5'd0;
      mem_fault  <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (good_op) begin
            state <= REQ;
            timer <= '0;
          end else if (fault_op) begin
            mem_fault <= 1'b1;
          end else if (in_valid) begin
            mem_result <= in_alu_result;
            reg_write  <= in_reg_write;
            rd_addr    <= in_rd_addr;
          end
        end
        REQ: begin
          timer <= timer + 1'b1;
          if (is_store && dmem_ready) begin
            state <= IDLE;
          end else if (expire) begin
            bus_error <= 1'b1;
            state     <= IDLE;
          end else if (dmem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (dmem_rvalid) begin
            mem_result <= load_value;
            reg_write  <= in_reg_write;
            rd_addr    <= in_rd_addr;
            state      <= IDLE;
          end else if (expire) begin
            bus_error <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a small
// word memory and an arithmetic reference model of load/store formatting.
module tb_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic        in_reg_write;
  logic [4:0]  in_rd_addr;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic [63:0] mem_result;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic        mem_fault;
  logic        bus_error;

  int checkCount = 0;
  int passCount  = 0;
  logic [63:0] memWords [0:7];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_result(mem_result), .reg_write(reg_write), .rd_addr(rd_addr),
    .mem_fault(mem_fault), .bus_error(bus_error)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, "_rw"}, {63'd0, reg_write}, 64'd0);
    checkOutput({tag, "_res"}, mem_result, 64'd0);
    checkOutput({tag, "_rd"}, {59'd0, rd_addr}, 64'd0);
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_alu_result = 64'd0; in_store_data = 64'd0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = 3'd0;
    in_reg_write = 1'b0; in_rd_addr = 5'd0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
  endtask

  function automatic int accessBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Load reference: shift the word down to the access offset, keep the
  // access width, then sign- or zero-extend depending on funct3[2].
  function automatic logic [63:0] loadModel(input logic [63:0] word, input int off, input logic [2:0] f3);
    int bytes;
    logic [63:0] v;
    logic [63:0] mask;
    bytes = accessBytes(f3);
    v = word >> (8 * off);
    if (bytes == 8) return v;
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    v = v & mask;
    if (!f3[2] && v[8 * bytes - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one EX/MEM instruction, plays the memory with the given latencies,
  // and checks every cycle until the instruction leaves the stage.
  task automatic applyStimulus(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                               input logic mr, input logic mw, input logic [2:0] f3,
                               input logic rw, input logic [4:0] rd,
                               input int readyDelay, input int rvalidDelay);
    logic memOp, isStore, illegal, fault, last;
    int off, bytes, idx;
    logic [63:0] expWdata;
    logic [15:0] strbWide;
    logic [7:0]  expStrb;
    memOp   = v & (mr | mw);
    isStore = mw & ~mr;
    off     = int'(alu[2:0]);
    idx     = int'(alu[5:3]);
    bytes   = accessBytes(f3);
    illegal = mr ? (f3 == 3'b111) : f3[2];
    fault   = memOp && (illegal || (off % bytes) != 0);
    expWdata = sd << (8 * off);
    strbWide = ((16'd1 << bytes) - 16'd1) << off;
    expStrb  = strbWide[7:0];

    in_valid = v; in_alu_result = alu; in_store_data = sd;
    in_mem_read = mr; in_mem_write = mw; in_funct3 = f3;
    in_reg_write = rw; in_rd_addr = rd;
    dmem_ready = 1'b0; dmem_rvalid = 1'($urandom % 2); dmem_rdata = {$urandom, $urandom};

    if (!memOp || fault) begin
      @(negedge clk);
      checkOutput("stall_idle", {63'd0, stall_out}, 64'd0);
      checkOutput("req_idle", {63'd0, dmem_req}, 64'd0);
      @(posedge clk); #1;
      if (fault) begin
        checkBubble("fault");
        checkOutput("mem_fault", {63'd0, mem_fault}, 64'd1);
      end else if (v) begin
        checkOutput("pass_res", mem_result, alu);
        checkOutput("pass_rw", {63'd0, reg_write}, {63'd0, rw});
        checkOutput("pass_rd", {59'd0, rd_addr}, {59'd0, rd});
        checkOutput("pass_fault", {63'd0, mem_fault}, 64'd0);
      end else begin
        checkBubble("invalid");
        checkOutput("inv_fault", {63'd0, mem_fault}, 64'd0);
      end
      checkOutput("berr_idle", {63'd0, bus_error}, 64'd0);
      return;
    end

    @(negedge clk);
    checkOutput("stall_accept", {63'd0, stall_out}, 64'd1);
    checkOutput("req_accept", {63'd0, dmem_req}, 64'd0);
    @(posedge clk); #1;
    checkBubble("accept");
    checkOutput("fault_good", {63'd0, mem_fault}, 64'd0);

    for (int w = 0; w <= readyDelay; w++) begin
      dmem_ready  = (w == readyDelay);
      dmem_rvalid = 1'($urandom % 2);
      dmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      checkOutput("req_high", {63'd0, dmem_req}, 64'd1);
      checkOutput("req_we", {63'd0, dmem_we}, {63'd0, isStore});
      checkOutput("req_addr", dmem_addr, {alu[63:3], 3'b000});
      if (isStore) begin
        checkOutput("req_wdata", dmem_wdata, expWdata);
        checkOutput("req_wstrb", {56'd0, dmem_wstrb}, {56'd0, expStrb});
      end
      checkOutput("stall_req", {63'd0, stall_out}, {63'd0, !(isStore && dmem_ready)});
      @(posedge clk); #1;
      checkBubble("req");
      checkOutput("berr_req", {63'd0, bus_error}, 64'd0);
    end
    dmem_ready = 1'b0;

    if (isStore) begin
      for (int i = 0; i < 8; i++)
        if (expStrb[i]) memWords[idx][8*i +: 8] = expWdata[8*i +: 8];
      dmem_rvalid = 1'b0;
      return;
    end

    for (int w = 0; w <= rvalidDelay; w++) begin
      last = (w == rvalidDelay);
      dmem_rvalid = last;
      dmem_rdata  = last ? memWords[idx] : {$urandom, $urandom};
      @(negedge clk);
      checkOutput("stall_wait", {63'd0, stall_out}, {63'd0, !last});
      checkOutput("req_wait", {63'd0, dmem_req}, 64'd0);
      @(posedge clk); #1;
      if (last) begin
        checkOutput("load_res", mem_result, loadModel(memWords[idx], off, f3));
        checkOutput("load_rw", {63'd0, reg_write}, {63'd0, rw});
        checkOutput("load_rd", {59'd0, rd_addr}, {59'd0, rd});
      end else begin
        checkBubble("wait");
      end
    end
    dmem_rvalid = 1'b0;
  endtask

  // Starts a good access and never completes it: either ready never comes,
  // or ready comes at once and rvalid never comes.
  task automatic runTimeout(input bit inWait);
    logic expReq;
    idleInputs();
    in_valid = 1'b1; in_alu_result = 64'h40; in_funct3 = 3'b011;
    in_mem_read = inWait; in_mem_write = !inWait; in_reg_write = 1'b1; in_rd_addr = 5'd4;
    @(negedge clk);
    checkOutput("to_stall0", {63'd0, stall_out}, 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < TO; k++) begin
      dmem_ready = inWait && (k == 0);
      expReq = inWait ? (k == 0) : 1'b1;
      @(negedge clk);
      checkOutput("to_req", {63'd0, dmem_req}, {63'd0, expReq});
      checkOutput("to_stall", {63'd0, stall_out}, {63'd0, k != TO - 1});
      @(posedge clk); #1;
      checkOutput("to_berr", {63'd0, bus_error}, {63'd0, k == TO - 1});
      checkBubble("to");
    end
    idleInputs();
    @(negedge clk);
    checkOutput("to_req_after", {63'd0, dmem_req}, 64'd0);
    checkOutput("to_stall_after", {63'd0, stall_out}, 64'd0);
    @(posedge clk); #1;
    checkOutput("to_berr_pulse", {63'd0, bus_error}, 64'd0);
  endtask

  initial begin
    logic v, mr, mw, rw;
    logic [2:0] f3, amask;
    logic [63:0] alu, sd;
    logic [4:0] rd;
    int kind;

    for (int i = 0; i < 8; i++) memWords[i] = {$urandom, $urandom};
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkBubble("reset");
    checkOutput("reset_req", {63'd0, dmem_req}, 64'd0);
    checkOutput("reset_stall", {63'd0, stall_out}, 64'd0);
    checkOutput("reset_addr", dmem_addr, 64'd0);
    checkOutput("reset_flags", {62'd0, mem_fault, bus_error}, 64'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 64'h1234, 64'd0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 0, 0);
    memWords[0] = 64'h0000_0000_8000_0000;
    applyStimulus(1'b1, 64'h1003, 64'd0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 2, 2);
    applyStimulus(1'b1, 64'h2006, 64'hBEEF, 1'b0, 1'b1, 3'b001, 1'b1, 5'd9, 0, 0);
    applyStimulus(1'b1, 64'h3002, 64'd0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd3, 0, 0);
    applyStimulus(1'b1, 64'h18, 64'd0, 1'b1, 1'b0, 3'b011, 1'b1, 5'd2, 0, 0);

    runTimeout(1'b0);
    runTimeout(1'b1);

    // Reset while waiting for a load response, then a late response.
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 0, 0);
    in_valid = 1'b1; in_alu_result = 64'h8; in_mem_read = 1'b1; in_funct3 = 3'b011;
    in_reg_write = 1'b1; in_rd_addr = 5'd6;
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkBubble("rst_wait");
    checkOutput("rst_wait_req", {63'd0, dmem_req}, 64'd0);
    checkOutput("rst_wait_stall", {63'd0, stall_out}, 64'd0);
    reset = 1'b0;
    in_valid = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk); #1;
    checkOutput("late_rw", {63'd0, reg_write}, 64'd0);
    checkOutput("late_res", mem_result, 64'd0);
    idleInputs();

    // Reset while a request is pending.
    in_valid = 1'b1; in_alu_result = 64'h10; in_mem_write = 1'b1; in_funct3 = 3'b011;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_req_pre", {63'd0, dmem_req}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    reset = 1'b0;
    checkOutput("rst_req_post", {63'd0, dmem_req}, 64'd0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      v  = (kind != 2);
      mr = (kind >= 3 && kind <= 5) || kind == 9 || (kind == 2 && $urandom % 2 == 1);
      mw = (kind >= 6) || (kind == 2 && $urandom % 2 == 1);
      if ($urandom % 8 == 0) f3 = 3'($urandom_range(0, 7));
      else if (mr) f3 = 3'($urandom_range(0, 6));
      else f3 = 3'($urandom_range(0, 3));
      alu = {$urandom, $urandom};
      case (f3[1:0])
        2'd0:    amask = 3'b111;
        2'd1:    amask = 3'b110;
        2'd2:    amask = 3'b100;
        default: amask = 3'b000;
      endcase
      if ($urandom % 4 != 0) alu[2:0] = alu[2:0] & amask;
      sd = {$urandom, $urandom};
      rw = 1'($urandom % 2);
      rd = 5'($urandom);
      applyStimulus(v, alu, sd, mr, mw, f3, rw, rd, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined RV64 core, between the EX/MEM register and the writeback stage. It issues loads and stores to the data memory over a valid/ready request and response-valid interface. It aligns, masks and sign- or zero-extends load data, and owns the MEM/WB pipeline register that drives `mem_result`, `reg_write` and `rd_addr` into writeback. While an access is outstanding it holds the upstream pipeline with `stall_out`.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of cycles spent in REQ plus WAIT before an access is abandoned.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction is present in EX/MEM.
- `in_alu_result` in 64: effective address for memory ops, result value for all other ops.
- `in_store_data` in 64: rs2 value for stores.
- `in_mem_read`, `in_mem_write` in 1 each: load or store op.
- `in_funct3` in 3: access size and signedness.
- `in_reg_write` in 1, `in_rd_addr` in 5: destination register control.
- `stall_out` out 1: EX/MEM holds its contents while this is high.
- `dmem_req` out 1, `dmem_ready` in 1: request handshake.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out 64: request address, `{in_alu_result[63:3],3'b000}`.
- `dmem_wdata` out 64, `dmem_wstrb` out 8: write data and byte strobes.
- `dmem_rvalid` in 1, `dmem_rdata` in 64: read response.
- `mem_result` out 64, `reg_write` out 1, `rd_addr` out 5: MEM/WB register outputs to writeback.
- `mem_fault` out 1, `bus_error` out 1: registered one-cycle fault pulses.

## Operation
- **Op classes**
  - A memory op is `in_valid & (in_mem_read | in_mem_write)`.
  - If both read and write are set, the op is a load.
- **Legal loads:** funct3 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. funct3 111 is illegal.
- **Legal stores:** funct3 000 sb, 001 sh, 010 sw, 011 sd. funct3 1xx is illegal.
- **Fault check**
  - An access faults if it is illegal or misaligned, where `off=in_alu_result[2:0]`.
  - Misaligned means: h with off[0]≠0, w with off[1:0]≠0, d with off≠0.
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE**
  - Non-memory valid op: MEM/WB loads `in_alu_result`, `in_reg_write`, `in_rd_addr`.
  - `in_valid=0`: MEM/WB loads a bubble (all fields 0).
  - Faulting memory op: MEM/WB loads a bubble, `mem_fault` is high the next cycle, no dmem request, no stall.
  - Good memory op: go to REQ and clear the timeout counter.
- **REQ**
  - `dmem_req=1`, held until `dmem_ready`.
  - Store accepted: MEM/WB loads a bubble (stores write no rd), go to IDLE.
  - Load accepted: go to WAIT.
- **WAIT**
  - On `dmem_rvalid`, MEM/WB loads the formatted load data, `in_reg_write`, `in_rd_addr`; go to IDLE.
  - `dmem_rvalid` seen in any other state is ignored.
- **Store formatting**
  - `dmem_wdata = in_store_data << (8*off)`.
  - `dmem_wstrb`: sb `8'h01<<off`, sh `8'h03<<off`, sw `8'h0F<<off`, sd `8'hFF`.
- **Load formatting**
  - `x = dmem_rdata >> (8*off)`.
  - Keep the low 8, 16, 32 or 64 bits of `x`.
  - lb/lh/lw sign-extend to 64 bits; lbu/lhu/lwu zero-extend.
- **Timeout**
  - A counter increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`: `bus_error` pulses the next cycle, MEM/WB loads a bubble, go to IDLE.
  - `dmem_req` drops and the stall releases.
- **Stall**
  - `stall_out = (IDLE & good mem op) | (REQ & ~(store & dmem_ready)) | (WAIT & ~dmem_rvalid)`.
  - Timeout-expiry cycles are excluded, so the stall releases.
  - Every stalled cycle loads a bubble into MEM/WB.
  - EX/MEM inputs are stable for the whole access, so this block does not latch them.

## Timing
- **Reset values**
  - Every output is 0 and the FSM is in IDLE.
  - The effect takes place on the first edge with `reset=1`.
  - A reset during REQ or WAIT abandons the access; `dmem_req` is low the cycle after the reset edge.
- **Latency**
  - Non-memory op: result in MEM/WB 1 cycle after it is presented.
  - Store with immediate ready: committed after 2 cycles.
  - Load with immediate ready and rvalid the next cycle: result 3 cycles after it is presented.
- **Stall release**
  - `stall_out` falls in the same cycle as the completing `dmem_ready` (store) or `dmem_rvalid` (load).
  - Upstream advances on that edge.
- **Request ordering**
  - At most one outstanding request.
  - `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` are stable while `dmem_req` is high.

## Test plan
- **ALU passthrough:** `in_valid=1`, no memory op, `alu_result=64'h1234`, `rd=5`, `reg_write=1` → next cycle `mem_result=64'h1234`, `rd_addr=5`, `reg_write=1`, `stall_out` never high.
- **lb sign-extend:** addr `0x1003`, funct3 000, `rdata=64'h00000000_80000000`, ready and rvalid each arrive after 2 waits → `mem_result=64'hFFFF_FFFF_FFFF_FF80`; `stall_out` high until the rvalid cycle; bubbles meanwhile.
- **sh byte lanes:** addr `0x2006`, `store_data=0xBEEF` → `dmem_wstrb=8'hC0`, `dmem_wdata[63:48]=16'hBEEF`, `dmem_we=1`; after accept, `reg_write=0`.
- **Misaligned lw:** addr `0x3002`, funct3 010 → no `dmem_req`, `mem_fault=1` for one cycle, bubble, no stall.
- **Timeout:** `TIMEOUT_CYCLES=4`, `dmem_ready` held 0 → `bus_error` pulse, `stall_out` released, FSM in IDLE.
- **Reset mid-access:** assert `reset` in WAIT, then apply a late `dmem_rvalid` → all outputs 0, late response ignored, `reg_write` stays 0.
